// File: rtl/n64_pkg.sv
// n64_pkg: shared states, command constants and reply lengths for the N64 joybus blocks
package n64_pkg;
  typedef enum logic [2:0] {IDLE, TX_BIT, TX_STOP, RX_WAIT, RX_SAMPLE, RX_STOP, DONE} state_t;
  localparam logic [7:0] CMD_INFO = 8'h00;
  localparam logic [7:0] CMD_STATUS = 8'h01;
  localparam logic [7:0] CMD_RESET = 8'hFF;
  localparam int RESP_BITS_INFO = 24;
  localparam int RESP_BITS_STATUS = 32;
  function automatic logic [5:0] resp_last_bit(input logic long_reply);
    return long_reply ? 6'(RESP_BITS_STATUS - 1) : 6'(RESP_BITS_INFO - 1);
  endfunction
endpackage

// File: rtl/n64_bus_sync.sv
// n64_bus_sync: two-flop synchroniser for the joybus line with falling/rising edge pulses
module n64_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic fall,
  output logic rise
);
  logic s1, s2, s3;
  always_ff @(posedge clk or posedge rst)
    if (rst) {s1, s2, s3} <= 3'b111;
    else {s1, s2, s3} <= {d, s1, s2};
  assign q = s2;
  assign fall = s3 & ~s2;
  assign rise = ~s3 & s2;
endmodule

// File: rtl/n64_console_poller.sv
// n64_console_poller: console-side joybus host; sends a command byte and decodes the reply.
// Define N64_CONSOLE_AUTOPOLL_EN to add a periodic status poll.
module n64_console_poller
  import n64_pkg::*;
#(
  parameter int CLKS_PER_US = 4,
  parameter int TIMEOUT_US = 8,
  parameter int POLL_PERIOD_US = 1000
) (
  input  logic        sample_clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  cmd,
  input  logic        bus_rx,
  output logic        bus_tx,
  output logic        busy,
  output logic [31:0] resp,
  output logic        resp_valid,
  output logic        timeout
);
  localparam int BIT_CLKS = 4 * CLKS_PER_US;
  localparam int PW = $clog2(BIT_CLKS) + 1;
  localparam int TO_CLKS = TIMEOUT_US * CLKS_PER_US;
  localparam int TW = $clog2(TO_CLKS + 1);
  localparam logic [PW-1:0] PH_BIT_END = PW'(BIT_CLKS - 1);
  localparam logic [PW-1:0] PH_US_END = PW'(CLKS_PER_US - 1);
  localparam logic [PW-1:0] PH_SAMPLE = PW'(2 * CLKS_PER_US - 1);
  localparam logic [PW-1:0] LOW_ONE = PW'(CLKS_PER_US);
  localparam logic [PW-1:0] LOW_ZERO = PW'(3 * CLKS_PER_US);
  localparam logic [TW-1:0] TO_END = TW'(TO_CLKS);

  state_t         state;
  logic [7:0]     cmd_r;
  logic           len32;
  logic [5:0]     bit_idx;
  logic [PW-1:0]  phase;
  logic [TW-1:0]  to_cnt;
  logic [31:0]    shreg;
  logic           stop_fell;
  logic           rx_q, rx_fall, rx_rise;
  logic           go;
  logic [7:0]     go_cmd;
  logic [PW-1:0]  ph_inc, low_len;
  logic [TW-1:0]  to_inc, to_sat;
  logic           to_hit;

  n64_bus_sync u_sync (
    .clk (sample_clk),
    .rst (reset),
    .d   (bus_rx),
    .q   (rx_q),
    .fall(rx_fall),
    .rise(rx_rise)
  );

`ifdef N64_CONSOLE_AUTOPOLL_EN
  localparam int POLL_CLKS = POLL_PERIOD_US * CLKS_PER_US;
  localparam int PCW = $clog2(POLL_CLKS);
  logic [PCW-1:0] poll_cnt;
  logic           auto_go;
  assign auto_go = poll_cnt == PCW'(POLL_CLKS - 1);
  always_ff @(posedge sample_clk or posedge reset)
    if (reset) poll_cnt <= '0;
    else poll_cnt <= auto_go ? '0 : poll_cnt + 1'b1;
  assign go = start | auto_go;
  assign go_cmd = start ? cmd : CMD_STATUS;
`else
  assign go = start;
  assign go_cmd = cmd;
`endif

  assign ph_inc = phase + 1'b1;
  assign low_len = cmd_r[bit_idx[2:0]] ? LOW_ONE : LOW_ZERO;
  assign to_inc = to_cnt + 1'b1;
  assign to_hit = to_inc == TO_END;
  assign to_sat = (to_cnt == TO_END) ? to_cnt : to_inc;

  always_ff @(posedge sample_clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      bus_tx <= 1'b1;
      busy <= 1'b0;
      resp <= '0;
      resp_valid <= 1'b0;
      timeout <= 1'b0;
      cmd_r <= '0;
      len32 <= 1'b0;
      bit_idx <= '0;
      phase <= '0;
      to_cnt <= '0;
      shreg <= '0;
      stop_fell <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      timeout <= 1'b0;
      case (state)
        IDLE:
          // a start coinciding with the timeout pulse is dropped
          if (go && !timeout) begin
            cmd_r <= go_cmd;
            len32 <= go_cmd == CMD_STATUS;
            bit_idx <= 6'd7;
            phase <= '0;
            shreg <= '0;
            bus_tx <= 1'b0;
            busy <= 1'b1;
            state <= TX_BIT;
          end
        TX_BIT:
          if (phase == PH_BIT_END) begin
            phase <= '0;
            bus_tx <= 1'b0;
            if (bit_idx == 6'd0) state <= TX_STOP;
            else bit_idx <= bit_idx - 1'b1;
          end else begin
            phase <= ph_inc;
            bus_tx <= ph_inc >= low_len;
          end
        TX_STOP:
          if (phase == PH_US_END) begin
            bus_tx <= 1'b1;
            to_cnt <= '0;
            bit_idx <= resp_last_bit(len32);
            state <= RX_WAIT;
          end else phase <= ph_inc;
        RX_WAIT:
          if (rx_fall) begin
            phase <= '0;
            to_cnt <= '0;
            state <= RX_SAMPLE;
          end else if (to_hit) begin
            timeout <= 1'b1;
            busy <= 1'b0;
            state <= IDLE;
          end else to_cnt <= to_sat;
        RX_SAMPLE:
          if (phase == PH_SAMPLE) begin
            shreg <= {shreg[30:0], rx_q};
            to_cnt <= '0;
            stop_fell <= 1'b0;
            if (bit_idx == 6'd0) state <= RX_STOP;
            else begin
              bit_idx <= bit_idx - 1'b1;
              state <= RX_WAIT;
            end
          end else phase <= ph_inc;
        RX_STOP:
          // a trailing 0 bit rises before the stop bit, so only a rise after its fall counts
          if (rx_rise && stop_fell) begin
            resp <= len32 ? shreg : {8'h00, shreg[23:0]};
            resp_valid <= 1'b1;
            busy <= 1'b0;
            state <= DONE;
          end else if (rx_fall) begin
            stop_fell <= 1'b1;
            to_cnt <= '0;
          end else if (to_hit) begin
            timeout <= 1'b1;
            busy <= 1'b0;
            state <= IDLE;
          end else to_cnt <= to_sat;
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_n64_console_poller.sv
// tb_n64_console_poller: table-driven joybus host bench with a reply model and pulse scoreboard
module tb_n64_console_poller;
  logic        clk = 1'b0;
  logic        reset, start, ctrl;
  logic [7:0]  cmd;
  logic        bus_tx, busy, resp_valid, timeout;
  logic [31:0] resp;
  wire         bus_rx = bus_tx & ctrl;

  always #5 clk = ~clk;

  n64_console_poller #(.CLKS_PER_US(4), .TIMEOUT_US(8), .POLL_PERIOD_US(1000)) dut (
    .sample_clk(clk),
    .reset(reset),
    .start(start),
    .cmd(cmd),
    .bus_rx(bus_rx),
    .bus_tx(bus_tx),
    .busy(busy),
    .resp(resp),
    .resp_valid(resp_valid),
    .timeout(timeout)
  );

  int checks = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {logic to; logic [31:0] r;} exp_t;
  exp_t        sbq[$];
  exp_t        e;
  logic [31:0] model_resp = '0;
  logic        prev_rv = 1'b0;

  always @(negedge clk) begin
    if (!reset && (resp_valid || timeout)) begin
      if (sbq.size() == 0) check("unexpected_pulse", {30'b0, resp_valid, timeout}, 32'h0);
      else begin
        e = sbq.pop_front();
        check("pulse_kind", {31'b0, timeout}, {31'b0, e.to});
        check(e.to ? "resp_kept" : "resp_value", resp, e.r);
      end
      if (resp_valid) check("rv_one_cycle", {31'b0, prev_rv}, 32'h0);
    end
    prev_rv = resp_valid;
  end

  typedef struct {
    logic [7:0]  c;
    logic [31:0] reply;
    int          nbits;
    logic        answer;
    logic        mid_start;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[6];

  task automatic run(input vec_t v);
    int wf_err;
    int n;
    logic exp_bit;
    @(negedge clk);
    cmd = v.c;
    start = 1'b1;
    if (v.answer) begin
      sbq.push_back('{1'b0, v.exp});
      model_resp = v.exp;
    end else sbq.push_back('{1'b1, model_resp});
    @(negedge clk);
    start = 1'b0;
    cmd = 8'($urandom);
    check("busy_rise", {31'b0, busy}, 32'h1);
    wf_err = 0;
    for (int b = 7; b >= 0; b--)
      for (int k = 0; k < 16; k++) begin
        exp_bit = k >= (v.c[b] ? 4 : 12);
        if (bus_tx !== exp_bit) wf_err++;
        @(negedge clk);
      end
    for (int k = 0; k < 4; k++) begin
      if (bus_tx !== 1'b0) wf_err++;
      @(negedge clk);
    end
    check("cmd_waveform", wf_err, 0);
    if (v.answer) begin
      repeat (4) @(negedge clk);
      for (int i = v.nbits - 1; i >= 0; i--) begin
        ctrl = 1'b0;
        if (v.mid_start && i == v.nbits / 2) start = 1'b1;
        repeat (v.reply[i] ? 4 : 12) @(negedge clk);
        start = 1'b0;
        ctrl = 1'b1;
        repeat (v.reply[i] ? 12 : 4) @(negedge clk);
      end
      ctrl = 1'b0;
      repeat (8) @(negedge clk);
      ctrl = 1'b1;
      n = 0;
      while (busy && n < 60) begin
        @(negedge clk);
        n++;
      end
      check("resp_latency", n, 3);
    end else begin
      n = 0;
      while (!timeout && n < 40) begin
        @(negedge clk);
        n++;
      end
      check("timeout_latency", n, 32);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start_on_timeout_ignored", {31'b0, busy}, 32'h0);
    end
    wf_err = 0;
    repeat (20) begin
      if (bus_tx !== 1'b1 || busy !== 1'b0) wf_err++;
      @(negedge clk);
    end
    check("idle_after", wf_err, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'h01, 32'h800000FF, 32, 1'b1, 1'b0, 32'h800000FF};
    vecs[1] = '{8'h00, 32'h00050002, 24, 1'b1, 1'b1, 32'h00050002};
    vecs[2] = '{8'hFF, 32'h00A5C30F, 24, 1'b1, 1'b0, 32'h00A5C30F};
    vecs[3] = '{8'h01, 32'h00000000, 32, 1'b0, 1'b0, 32'h00000000};
    vecs[4] = '{8'h01, 32'hFFFFFFFF, 32, 1'b1, 1'b0, 32'hFFFFFFFF};
    vecs[5] = '{8'h01, 32'h12345678, 32, 1'b1, 1'b1, 32'h12345678};
    reset = 1'b1;
    start = 1'b0;
    ctrl = 1'b1;
    cmd = 8'h00;
    repeat (3) @(negedge clk);
    start = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_bus_tx", {31'b0, bus_tx}, 32'h1);
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_resp", resp, 32'h0);
    check("reset_pulses", {30'b0, resp_valid, timeout}, 32'h0);
    start = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 6; i++) run(vecs[i]);
    // abort in the middle of bit 3 of a status command
    @(negedge clk);
    cmd = 8'h01;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (68) @(negedge clk);
    check("bit3_low", {31'b0, bus_tx}, 32'h0);
    #2 reset = 1'b1;
    #1 check("async_reset_tx", {31'b0, bus_tx}, 32'h1);
    check("async_reset_busy", {31'b0, busy}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (60) @(negedge clk);
    check("reset_abort_idle", {30'b0, busy, ~bus_tx}, 32'h0);
    check("reset_abort_resp", resp, 32'h0);
    model_resp = '0;
    run(vecs[0]);
    check("scoreboard_empty", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
